// File: rtl/cache_pkg.sv
// rtl/cache_pkg.sv - shared sizing defaults, consumer index type and round-robin pick helper
package cache_pkg;

  localparam int CACHE_WIDTH_DEF = 162;
  localparam int ADDR_WIDTH_DEF  = 6;
  localparam int NUM_CONS        = 2;

  typedef enum logic {
    CONS0 = 1'b0,
    CONS1 = 1'b1
  } cons_e;

  // With both consumers requesting, the one that did not win last time goes next.
  function automatic logic [NUM_CONS-1:0] rr_pick(input logic [NUM_CONS-1:0] req,
                                                   input cons_e last);
    logic [NUM_CONS-1:0] pick;
    pick = '0;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = (last == CONS0) ? 2'b10 : 2'b01;
      default: pick = '0;
    endcase
    return pick;
  endfunction

endpackage

// File: rtl/cache_arb_if.sv
// rtl/cache_arb_if.sv - producer/consumer bus of the cache arbiter
interface cache_arb_if #(
  parameter int CACHE_WIDTH = cache_pkg::CACHE_WIDTH_DEF,
  parameter int ADDR_WIDTH  = cache_pkg::ADDR_WIDTH_DEF
);

  logic                            wr_valid;
  logic [CACHE_WIDTH-1:0]          wr_data;
  logic                            wr_ready;
  logic [cache_pkg::NUM_CONS-1:0]  rd_req;
  logic [cache_pkg::NUM_CONS-1:0]  rd_gnt;
  logic [cache_pkg::NUM_CONS-1:0]  rd_valid;
  logic [CACHE_WIDTH-1:0]          rd_data;
  logic                            empty;
  logic                            full;
  logic [ADDR_WIDTH:0]             count;

  modport master (
    output wr_valid, wr_data, rd_req,
    input  wr_ready, rd_gnt, rd_valid, rd_data, empty, full, count
  );

  modport slave (
    input  wr_valid, wr_data, rd_req,
    output wr_ready, rd_gnt, rd_valid, rd_data, empty, full, count
  );

endinterface

// File: rtl/cache_arb_ram.sv
// rtl/cache_arb_ram.sv - simple dual-port RAM, one write port, registered read port
module cache_arb_ram #(
  parameter int WIDTH      = 162,
  parameter int ADDR_WIDTH = 6
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic [ADDR_WIDTH-1:0] waddr,
  input  logic [WIDTH-1:0]      wdata,
  input  logic                  re,
  input  logic [ADDR_WIDTH-1:0] raddr,
  output logic [WIDTH-1:0]      rdata
);

  logic [WIDTH-1:0] mem [2**ADDR_WIDTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // Only the read register is cleared; the array itself keeps stale contents.
  always_ff @(posedge clk) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/cache_arb.sv
// rtl/cache_arb.sv - single-producer entry cache shared by two round-robin consumers
module cache_arb
  import cache_pkg::*;
#(
  parameter int CACHE_WIDTH = CACHE_WIDTH_DEF,
  parameter int ADDR_WIDTH  = ADDR_WIDTH_DEF
) (
  input logic        clk,
  input logic        rst_n,
  input logic        clk_en,
  cache_arb_if.slave bus
);

  localparam int DEPTH = 2**ADDR_WIDTH;

  logic [ADDR_WIDTH-1:0] wr_ptr, rd_ptr;
  logic [ADDR_WIDTH:0]   count_q, count_nxt;
  logic                  empty_q, full_q;
  logic                  wr_ready, do_wr, do_rd;
  logic [NUM_CONS-1:0]   gnt, rd_valid_q;
  cons_e                 last_gnt;

  assign wr_ready = clk_en & ~full_q;
  assign do_wr    = bus.wr_valid & wr_ready;
  // Grants look only at registered occupancy, so a same-cycle write into an empty cache is never bypassed.
  assign gnt      = (clk_en & ~empty_q) ? rr_pick(bus.rd_req, last_gnt) : '0;
  assign do_rd    = |gnt;

  always_comb begin
    count_nxt = count_q;
    if (do_wr && !do_rd)      count_nxt = count_q + (ADDR_WIDTH+1)'(1);
    else if (!do_wr && do_rd) count_nxt = count_q - (ADDR_WIDTH+1)'(1);
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count_q    <= '0;
      empty_q    <= 1'b1;
      full_q     <= 1'b0;
      rd_valid_q <= '0;
      last_gnt   <= CONS1;
    end else if (clk_en) begin
      if (do_wr) wr_ptr <= wr_ptr + ADDR_WIDTH'(1);
      if (do_rd) begin
        rd_ptr   <= rd_ptr + ADDR_WIDTH'(1);
        last_gnt <= gnt[1] ? CONS1 : CONS0;
      end
      count_q    <= count_nxt;
      empty_q    <= (count_nxt == '0);
      full_q     <= (count_nxt == (ADDR_WIDTH+1)'(DEPTH));
      rd_valid_q <= gnt;
    end
  end

  cache_arb_ram #(
    .WIDTH      (CACHE_WIDTH),
    .ADDR_WIDTH (ADDR_WIDTH)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (do_wr),
    .waddr (wr_ptr),
    .wdata (bus.wr_data),
    .re    (do_rd),
    .raddr (rd_ptr),
    .rdata (bus.rd_data)
  );

  assign bus.wr_ready = wr_ready;
  assign bus.rd_gnt   = gnt;
  assign bus.rd_valid = rd_valid_q;
  assign bus.empty    = empty_q;
  assign bus.full     = full_q;
  assign bus.count    = count_q;

endmodule
